// File: rtl/conv_stream_engine.sv
// Streaming KxK 2-D convolution over raster-order AXI4-Stream pixels.
// Line buffers feed a sliding window; a 2-stage MAC/saturate pipeline produces one result per valid window.
module conv_stream_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int KSIZE      = 3,
  parameter int MAX_WIDTH  = 1024,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(KSIZE*KSIZE) + 1
) (
  input  logic                              axi_clk,
  input  logic                              axi_reset,
  input  logic                              start,
  input  logic [15:0]                       image_width,
  input  logic [15:0]                       image_height,
  input  logic [4:0]                        out_shift,
  input  logic                              coef_we,
  input  logic [$clog2(KSIZE*KSIZE)-1:0]    coef_addr,
  input  logic [COEF_WIDTH-1:0]             coef_data,
  output logic                              busy,
  output logic                              done,
  output logic                              err_size,
  output logic                              err_tlast,
  input  logic                              s_axis_valid,
  output logic                              s_axis_ready,
  input  logic [DATA_WIDTH-1:0]             s_axis_data,
  input  logic                              s_axis_last,
  output logic                              m_axis_valid,
  input  logic                              m_axis_ready,
  output logic [OUT_WIDTH-1:0]              m_axis_data,
  output logic                              m_axis_last
);

  localparam int NCOEF = KSIZE * KSIZE;
  localparam int CA_W  = $clog2(NCOEF);
  localparam int LB_AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [15:0] K_W16   = 16'(KSIZE);
  localparam logic [15:0] K1_W16  = 16'(KSIZE - 1);
  localparam logic [15:0] MAX_W16 = 16'(MAX_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    $signed({{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}});

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t state_q, state_d;
  logic [15:0] width_q, width_d, height_q, height_d;
  logic [15:0] col_q, col_d, row_q, row_d;
  logic [4:0]  shift_q, shift_d;
  logic signed [COEF_WIDTH-1:0] coef_q [NCOEF];
  logic signed [COEF_WIDTH-1:0] coef_d [NCOEF];
  logic [DATA_WIDTH-1:0] win_q [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] win_d [KSIZE][KSIZE];
  logic win_valid_q, win_valid_d, win_last_q, win_last_d;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [OUT_WIDTH-1:0] m_data_q, m_data_d;
  logic done_q, done_d, err_size_q, err_size_d, err_tlast_q, err_tlast_d;

  logic [DATA_WIDTH-1:0] lb_mem [KSIZE-1][MAX_WIDTH];
  logic [DATA_WIDTH-1:0] col_data [KSIZE];
  logic [LB_AW-1:0] lb_addr;
  logic stall, s_ready_c, accept, is_final;
  logic signed [ACC_WIDTH-1:0] sum_c, shifted_c;
  logic [OUT_WIDTH-1:0] sat_c;

  assign lb_addr   = col_q[LB_AW-1:0];
  assign stall     = m_valid_q && !m_axis_ready;
  assign s_ready_c = (state_q == ST_RUN) && !stall;
  assign accept    = s_axis_valid && s_ready_c;
  assign is_final  = (row_q == height_q - 16'd1) && (col_q == width_q - 16'd1);

  // Column entering the window: buffered rows oldest first, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < KSIZE - 1; r++) col_data[r] = lb_mem[r][lb_addr];
    col_data[KSIZE-1] = s_axis_data;
  end

  always_ff @(posedge axi_clk) begin
    if (accept) begin
      for (int i = 0; i < KSIZE - 1; i++) lb_mem[i][lb_addr] <= col_data[i+1];
    end
  end

  always_comb begin
    sum_c = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        sum_c = sum_c + $signed(ACC_WIDTH'(win_q[r][c])) * ACC_WIDTH'(coef_q[r*KSIZE+c]);
      end
    end
  end

  always_comb begin
    shifted_c = acc_q >>> shift_q;
    if (shifted_c[ACC_WIDTH-1])   sat_c = '0;
    else if (shifted_c > OUT_MAX) sat_c = '1;
    else                          sat_c = shifted_c[OUT_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    shift_d     = shift_q;
    col_d       = col_q;
    row_d       = row_q;
    coef_d      = coef_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    acc_d       = acc_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_data_d    = m_data_q;
    done_d      = 1'b0;
    err_size_d  = err_size_q;
    err_tlast_d = err_tlast_q;

    if (state_q == ST_IDLE && coef_we) begin
      for (int i = 0; i < NCOEF; i++) begin
        if (coef_addr == CA_W'(i)) coef_d[i] = coef_data;
      end
    end

    // Whole pipeline freezes while the downstream holds off a presented result.
    if (!stall) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
      s1_valid_d  = win_valid_q;
      s1_last_d   = win_last_q;
      acc_d       = sum_c;
      m_valid_d   = s1_valid_q;
      m_last_d    = s1_last_q;
      m_data_d    = sat_c;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (image_width >= K_W16 && image_width <= MAX_W16 && image_height >= K_W16) begin
            width_d  = image_width;
            height_d = image_height;
            shift_d  = out_shift;
            col_d    = '0;
            row_d    = '0;
            state_d  = ST_RUN;
          end else begin
            err_size_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) win_d[r][c] = win_q[r][c+1];
            win_d[r][KSIZE-1] = col_data[r];
          end
          win_valid_d = (col_q >= K1_W16) && (row_q >= K1_W16);
          win_last_d  = is_final;
          if (s_axis_last != is_final) err_tlast_d = 1'b1;
          if (is_final) begin
            state_d = ST_FLUSH;
          end else if (col_q == width_q - 16'd1) begin
            col_d = '0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      end
      ST_FLUSH: begin
        if (m_valid_q && m_axis_ready && m_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q     <= ST_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      shift_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      coef_q      <= '{default: '0};
      win_q       <= '{default: '{default: '0}};
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      done_q      <= 1'b0;
      err_size_q  <= 1'b0;
      err_tlast_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      shift_q     <= shift_d;
      col_q       <= col_d;
      row_q       <= row_d;
      coef_q      <= coef_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      done_q      <= done_d;
      err_size_q  <= err_size_d;
      err_tlast_q <= err_tlast_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err_size     = err_size_q;
  assign err_tlast    = err_tlast_q;
  assign s_axis_ready = s_ready_c;
  assign m_axis_valid = m_valid_q;
  assign m_axis_data  = m_data_q;
  assign m_axis_last  = m_last_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench for conv_stream_engine (KSIZE=3, 8-bit data).
// Expected results come from a direct evaluation of the convolution sum over the frame array.
module tb_conv_stream_engine;

  localparam int K = 3;

  logic axiClk = 1'b0;
  logic axiReset = 1'b1;
  logic start = 1'b0;
  logic [15:0] imageWidth = '0;
  logic [15:0] imageHeight = '0;
  logic [4:0] outShift = '0;
  logic coefWe = 1'b0;
  logic [3:0] coefAddr = '0;
  logic [7:0] coefData = '0;
  logic busy, done, errSize, errTlast;
  logic sValid = 1'b0;
  logic sReady;
  logic [7:0] sData = '0;
  logic sLast = 1'b0;
  logic mValid;
  logic mReady = 1'b1;
  logic [7:0] mData;
  logic mLast;

  int assertCount = 0;
  int failCount = 0;
  int pix [0:63];
  int coefModel [0:8];
  int expData [$];
  int expLast [$];
  int recvData [$];
  bit randomReady = 1'b0;
  bit pendingDone = 1'b0;
  bit prevStall = 1'b0;
  int stallData, stallLast;

  conv_stream_engine #(.DATA_WIDTH(8), .COEF_WIDTH(8), .OUT_WIDTH(8), .KSIZE(K), .MAX_WIDTH(1024)) dut (
    .axi_clk(axiClk), .axi_reset(axiReset), .start(start),
    .image_width(imageWidth), .image_height(imageHeight), .out_shift(outShift),
    .coef_we(coefWe), .coef_addr(coefAddr), .coef_data(coefData),
    .busy(busy), .done(done), .err_size(errSize), .err_tlast(errTlast),
    .s_axis_valid(sValid), .s_axis_ready(sReady), .s_axis_data(sData), .s_axis_last(sLast),
    .m_axis_valid(mValid), .m_axis_ready(mReady), .m_axis_data(mData), .m_axis_last(mLast)
  );

  always #5 axiClk = ~axiClk;

  // Downstream ready: held high, or coin-flipped each cycle for backpressure tests
  always @(posedge axiClk) begin
    #1;
    mReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Per-cycle scoreboard: every output handshake against the model queue,
  // stall stability, ready-drop during stall and the done pulse timing
  always @(negedge axiClk) begin
    if (axiReset) begin
      pendingDone = 1'b0;
      prevStall = 1'b0;
    end else begin
      checkOutput("done_pulse", int'(done), int'(pendingDone));
      pendingDone = 1'b0;
      if (prevStall) begin
        checkOutput("stall_valid_held", int'(mValid), 1);
        checkOutput("stall_data_stable", int'(mData), stallData);
        checkOutput("stall_last_stable", int'(mLast), stallLast);
      end
      prevStall = 1'b0;
      if (mValid && mReady) begin
        if (expData.size() == 0) begin
          checkOutput("unexpected_output", int'(mData), -1);
        end else begin
          checkOutput("m_data", int'(mData), expData.pop_front());
          checkOutput("m_last", int'(mLast), expLast.pop_front());
        end
        recvData.push_back(int'(mData));
        if (mLast) pendingDone = 1'b1;
      end else if (mValid) begin
        checkOutput("s_ready_low_in_stall", int'(sReady), 0);
        prevStall = 1'b1;
        stallData = int'(mData);
        stallLast = int'(mLast);
      end
    end
  end

  // Reference model: plain convolution over the frame, shift, then clamp
  task automatic buildModel(input int w, input int h, input int sh);
    for (int y = 0; y <= h - K; y++) begin
      for (int x = 0; x <= w - K; x++) begin
        int s = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            s += coefModel[r*K+c] * pix[(y+r)*w + x + c];
        s = s >>> sh;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        expData.push_back(s);
        expLast.push_back((y == h - K && x == w - K) ? 1 : 0);
      end
    end
  endtask

  task automatic writeCoef(input int addr, input int data, input bit honoured);
    coefWe = 1'b1; coefAddr = 4'(addr); coefData = 8'(data);
    @(posedge axiClk); #1;
    coefWe = 1'b0;
    if (honoured) coefModel[addr] = data;
  endtask

  task automatic startFrame(input int w, input int h, input int sh, input bit we, input int addr, input int data);
    start = 1'b1; imageWidth = 16'(w); imageHeight = 16'(h); outShift = 5'(sh);
    coefWe = we; coefAddr = 4'(addr); coefData = 8'(data);
    @(posedge axiClk); #1;
    start = 1'b0; coefWe = 1'b0;
    if (we) coefModel[addr] = data;
  endtask

  task automatic applyStimulus(input int n, input int lastIdx, input bit finalLast, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit accepted = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        sValid = 1'b0;
        @(posedge axiClk); #1;
      end
      sData = 8'(pix[i]);
      sLast = (i == lastIdx) || (finalLast && i == n - 1);
      sValid = 1'b1;
      for (int t = 0; t < 200 && !accepted; t++) begin
        @(negedge axiClk);
        accepted = sReady;
        @(posedge axiClk); #1;
      end
      if (!accepted) begin
        checkOutput("s_accept_timeout", 0, 1);
        break;
      end
    end
    sValid = 1'b0;
    sLast = 1'b0;
  endtask

  task automatic waitDone();
    for (int t = 0; t < 400; t++) begin
      @(negedge axiClk);
      if (done) break;
    end
    checkOutput("done_seen", int'(done), 1);
    checkOutput("busy_fall_with_done", int'(busy), 0);
    @(posedge axiClk); #1;
    checkOutput("outputs_drained", expData.size(), 0);
  endtask

  task automatic runFrame(input int w, input int h, input int sh, input int lastIdx, input bit finalLast, input bit gaps);
    recvData.delete();
    startFrame(w, h, sh, 1'b0, 0, 0);
    checkOutput("busy_after_start", int'(busy), 1);
    buildModel(w, h, sh);
    applyStimulus(w * h, lastIdx, finalLast, gaps);
    waitDone();
  endtask

  task automatic checkResetState();
    checkOutput("rst_s_ready", int'(sReady), 0);
    checkOutput("rst_m_valid", int'(mValid), 0);
    checkOutput("rst_m_data", int'(mData), 0);
    checkOutput("rst_m_last", int'(mLast), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err_size", int'(errSize), 0);
    checkOutput("rst_err_tlast", int'(errTlast), 0);
  endtask

  task automatic setKernel(input int center, input int others);
    for (int i = 0; i < 9; i++) writeCoef(i, (i == 4) ? center : others, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) coefModel[i] = 0;
    repeat (2) @(posedge axiClk);
    #1 axiReset = 1'b0;
    checkResetState();

    // Identity kernel on 5x4 ramp, with exact output latency and done timing
    setKernel(1, 0);
    for (int i = 0; i < 20; i++) pix[i] = i + 1;
    recvData.delete();
    startFrame(5, 4, 0, 1'b0, 0, 0);
    checkOutput("busy_after_start", int'(busy), 1);
    buildModel(5, 4, 0);
    checkOutput("model_first", expData[0], 7);
    checkOutput("model_sixth", expData[5], 14);
    applyStimulus(20, -1, 1'b1, 1'b0);
    @(negedge axiClk);
    checkOutput("lat_n0_data", int'(mData), 12);
    @(negedge axiClk);
    checkOutput("lat_n1_data", int'(mData), 13);
    checkOutput("lat_n1_last", int'(mLast), 0);
    @(negedge axiClk);
    checkOutput("lat_n2_valid", int'(mValid), 1);
    checkOutput("lat_n2_last", int'(mLast), 1);
    checkOutput("lat_n2_data", int'(mData), 14);
    @(negedge axiClk);
    checkOutput("lat_n3_done", int'(done), 1);
    checkOutput("lat_n3_busy", int'(busy), 0);
    @(posedge axiClk); #1;
    checkOutput("f1_count", recvData.size(), 6);
    if (recvData.size() == 6) begin
      checkOutput("f1_out0", recvData[0], 7);
      checkOutput("f1_out2", recvData[2], 9);
      checkOutput("f1_out3", recvData[3], 12);
    end
    checkOutput("f1_err_tlast", int'(errTlast), 0);

    // Saturation high then low
    setKernel(20, -1);
    for (int i = 0; i < 12; i++) pix[i] = 255;
    runFrame(3, 3, 0, -1, 1'b1, 1'b0);
    if (recvData.size() == 1) checkOutput("sat_high", recvData[0], 255);
    writeCoef(4, -1, 1'b1);
    runFrame(4, 3, 0, -1, 1'b1, 1'b0);
    checkOutput("sat_low_count", recvData.size(), 2);
    if (recvData.size() == 2) checkOutput("sat_low", recvData[1], 0);

    // Box kernel under random backpressure and input gaps
    setKernel(1, 1);
    for (int i = 0; i < 30; i++) pix[i] = 9;
    randomReady = 1'b1;
    runFrame(6, 5, 3, -1, 1'b1, 1'b1);
    checkOutput("box_count", recvData.size(), 12);
    foreach (recvData[i]) checkOutput("box_value", recvData[i], 10);
    for (int i = 0; i < 35; i++) pix[i] = (i * 37 + 11) % 256;
    runFrame(7, 5, 3, -1, 1'b1, 1'b1);
    randomReady = 1'b0;

    // Misplaced s_axis_last on pixel 7 still completes the frame
    setKernel(1, 0);
    for (int i = 0; i < 20; i++) pix[i] = i + 1;
    checkOutput("tlast_clear_before", int'(errTlast), 0);
    runFrame(5, 4, 0, 6, 1'b1, 1'b0);
    checkOutput("tlast_err_set", int'(errTlast), 1);
    checkOutput("tlast_count", recvData.size(), 6);

    // Bad size, then IDLE coef writes, then ignored RUN-time write
    startFrame(2, 4, 0, 1'b0, 0, 0);
    checkOutput("size_err_set", int'(errSize), 1);
    checkOutput("size_busy_low", int'(busy), 0);
    setKernel(0, 0);
    writeCoef(0, 1, 1'b1);
    for (int i = 0; i < 16; i++) pix[i] = i + 1;
    recvData.delete();
    startFrame(4, 4, 0, 1'b0, 0, 0);
    buildModel(4, 4, 0);
    writeCoef(0, 5, 1'b0);
    checkOutput("busy_in_run", int'(busy), 1);
    applyStimulus(16, -1, 1'b1, 1'b0);
    waitDone();
    checkOutput("run_write_count", recvData.size(), 4);
    if (recvData.size() == 4) begin
      checkOutput("run_write_ignored0", recvData[0], 1);
      checkOutput("run_write_ignored3", recvData[3], 6);
    end

    // Reset mid-frame, then a fresh frame with start and coef write together
    setKernel(1, 0);
    for (int i = 0; i < 20; i++) pix[i] = i + 1;
    startFrame(5, 4, 0, 1'b0, 0, 0);
    applyStimulus(12, -1, 1'b0, 1'b0);
    axiReset = 1'b1;
    expData.delete(); expLast.delete(); recvData.delete();
    for (int i = 0; i < 9; i++) coefModel[i] = 0;
    @(posedge axiClk); #1;
    axiReset = 1'b0;
    checkResetState();
    startFrame(5, 4, 0, 1'b1, 4, 1);
    checkOutput("restart_busy", int'(busy), 1);
    buildModel(5, 4, 0);
    applyStimulus(20, -1, 1'b1, 1'b0);
    waitDone();
    checkOutput("restart_count", recvData.size(), 6);
    if (recvData.size() == 6) begin
      checkOutput("restart_out0", recvData[0], 7);
      checkOutput("restart_out5", recvData[5], 14);
    end

    // Missing s_axis_last on the final pixel
    checkOutput("tlast_clear_after_reset", int'(errTlast), 0);
    runFrame(5, 4, 0, -1, 1'b0, 1'b0);
    checkOutput("tlast_missing_final", int'(errTlast), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
